seg7_scan_driver: RTL and testbench
===================================

SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: digit count, legal range 1..8.
REQ-002 SHALL have parameter TICKS_PER_DIGIT, default 50000: clk cycles per digit slot, legal minimum 2.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port value  input  4*NUM_DIGITS  hex digits; nibble k = digit k, with digit 0 least significant.
REQ-006 SHALL have port load_valid  input  1  value offered.
REQ-007 SHALL have port load_ready  output  1  pending buffer empty, load accepted.
REQ-008 SHALL have port blank_mask  input  NUM_DIGITS  bit k=1 forces digit k dark; sampled live.
REQ-009 SHALL have port seg  output  7  segments a..g on bits 0..6, active-low.
REQ-010 SHALL have port digit_en  output  NUM_DIGITS  digit enables, active-low.
REQ-011 SHALL have port digit_idx  output  3  index of the current slot.

Function
REQ-012 SHALL decode nibbles 0-F, active-low, to 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E (hex, seg[6:0]).
REQ-013 SHALL run a tick counter 0..TICKS_PER_DIGIT-1; at wrap, digit_idx increments, wrapping NUM_DIGITS-1 -> 0.
REQ-014 SHALL register seg, digit_en and digit_idx: no combinational path from inputs to outputs.
REQ-015 SHALL, during tick 0 of every slot (ghost guard), drive all digit_en high and load seg with the new slot's code.
REQ-016 SHALL, during ticks 1..TICKS_PER_DIGIT-1, drive digit_en[digit_idx] low and all other enables high.
REQ-017 SHALL drive seg 7F for slot k when blank_mask[k]=1, whatever the nibble value.
REQ-018 SHALL hold a display register and a one-entry pending register with a full flag.
REQ-019 SHALL define the transfer as the handshake load_valid & load_ready.
REQ-020 SHALL drive load_ready as the inverse of the pending full flag.
REQ-021 SHALL, on a transfer, capture value into pending and set full.
REQ-022 SHALL define the frame boundary as the cycle where digit_idx=NUM_DIGITS-1 and tick=TICKS_PER_DIGIT-1.
REQ-023 SHALL, at the frame boundary with full set, move pending into display and clear full, so that no frame shows mixed values.
REQ-024 SHALL, on a transfer coincident with the frame boundary while full is clear, capture into pending only; display updates at the next boundary.
REQ-025 SHALL leave load_valid without effect while load_ready is low; the value is not captured.
REQ-026 SHALL make one frame NUM_DIGITS*TICKS_PER_DIGIT cycles; the worst-case accepted-to-visible delay is two frames.
REQ-027 SHALL, with NUM_DIGITS=1, treat every slot wrap as a frame boundary.

Reset
REQ-028 SHALL, while rst is high, hold seg=7F, digit_en all ones, digit_idx=0, tick=0, display=0, full=0 and load_ready=1.
REQ-029 SHALL, on rst asserted mid-frame, discard pending and display contents immediately.
REQ-030 SHALL, after reset release, begin scanning at slot 0, tick 0, on the first clk edge.

Configuration
REQ-031 SHALL, with macro SEG7_LEADING_ZERO_BLANK_EN defined, blank (seg 7F) every digit above the most significant nonzero nibble of display; digit 0 is never blanked this way.
REQ-032 SHALL, without SEG7_LEADING_ZERO_BLANK_EN, display zero nibbles as 40 and contain no leading-zero logic.
REQ-033 SHALL OR the leading-zero blanking with blank_mask when the macro is defined.

Verification (NUM_DIGITS=4, TICKS_PER_DIGIT=4)
REQ-034 SHALL check: rst pulse -> seg=7F, digit_en=F, digit_idx=0, load_ready=1 during and 1 cycle after.
REQ-035 SHALL check: load 1234 -> load_ready low until the first boundary; next frame slot 0 seg=19, digit_en=1110 on ticks 1-3; slot 3 seg=79, digit_en=0111.
REQ-036 SHALL check: load AAAA then hold load_valid with 5555 -> 5555 accepted only the cycle after the boundary; display never shows a mix of A and 5.
REQ-037 SHALL check: blank_mask=0100 with display 8888 -> slot 2 seg=7F, slots 0,1,3 seg=00.
REQ-038 SHALL check: display 0042 -> slots 3,2 seg=7F with the macro defined, 40 without; slot 0 seg=24 in both builds.
REQ-039 SHALL check: rst asserted at slot 2 tick 2 with pending full -> immediate reset values, and digit_en stays F through the next tick 0.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Bus bundle for the seven-segment scan driver: load handshake, live blank mask
// and the registered display outputs.
interface seg7_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] value;
  logic                    load_valid;
  logic                    load_ready;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [6:0]              seg;
  logic [NUM_DIGITS-1:0]   digit_en;
  logic [2:0]              digit_idx;

  modport master (
    output value, load_valid, blank_mask,
    input  load_ready, seg, digit_en, digit_idx
  );

  modport slave (
    input  value, load_valid, blank_mask,
    output load_ready, seg, digit_en, digit_idx
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex seven-segment driver with a one-entry pending buffer swapped in at frame ends.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN darkens digits above the top nonzero nibble.
module seg7_scan_driver #(
  parameter int NUM_DIGITS      = 4,
  parameter int TICKS_PER_DIGIT = 50000
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);
  localparam int TW = (TICKS_PER_DIGIT > 2) ? $clog2(TICKS_PER_DIGIT) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  logic [TW-1:0]         tick_q, tick_d;
  logic [2:0]            idx_q, idx_d;
  logic                  run_q, run_d;
  logic [DW-1:0]         display_q, display_d;
  logic [DW-1:0]         pending_q, pending_d;
  logic                  full_q, full_d;
  logic [6:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_en_q, digit_en_d;

  logic       tick_last, idx_last, frame_end, xfer, blank;
  logic [7:0] blank_ext;
  logic [3:0] nib [8];

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  assign tick_last = (tick_q == TW'(TICKS_PER_DIGIT - 1));
  assign idx_last  = (idx_q == 3'(NUM_DIGITS - 1));
  assign frame_end = run_q & tick_last & idx_last;
  assign xfer      = bus.load_valid & ~full_q;

  // run_q is low only for the first edge after reset, which lands on slot 0 tick 0
  always_comb begin
    tick_d = tick_q;
    idx_d  = idx_q;
    run_d  = 1'b1;
    if (!run_q) begin
      tick_d = '0;
      idx_d  = 3'd0;
    end else if (tick_last) begin
      tick_d = '0;
      idx_d  = idx_last ? 3'd0 : idx_q + 3'd1;
    end else begin
      tick_d = tick_q + TW'(1);
    end
  end

  // Full buffer blocks the handshake, so a swap and a capture never coincide
  always_comb begin
    display_d = display_q;
    pending_d = pending_q;
    full_d    = full_q;
    if (frame_end && full_q) begin
      display_d = pending_q;
      full_d    = 1'b0;
    end else if (xfer) begin
      pending_d = bus.value;
      full_d    = 1'b1;
    end
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_nib
    if (gi < NUM_DIGITS) begin : g_used
      assign nib[gi] = display_d[4*gi +: 4];
    end else begin : g_pad
      assign nib[gi] = 4'h0;
    end
  end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic [7:0] nz;
  logic [2:0] msd;
  for (genvar gi = 0; gi < 8; gi++) begin : g_nz
    assign nz[gi] = |nib[gi];
  end
  always_comb begin
    msd = 3'd0;
    for (int k = 0; k < 8; k++) begin
      if (nz[k]) msd = 3'(k);
    end
  end
`endif

  // Outputs are computed for the slot that becomes current on the next edge
  always_comb begin
    blank_ext = 8'(bus.blank_mask);
    blank     = blank_ext[idx_d];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    blank     = blank | (idx_d > msd);
`endif
    seg_d      = blank ? 7'h7F : hex7(nib[idx_d]);
    digit_en_d = (tick_d == '0) ? '1 : NUM_DIGITS'(~(8'd1 << idx_d));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q     <= '0;
      idx_q      <= 3'd0;
      run_q      <= 1'b0;
      display_q  <= '0;
      pending_q  <= '0;
      full_q     <= 1'b0;
      seg_q      <= 7'h7F;
      digit_en_q <= '1;
    end else begin
      tick_q     <= tick_d;
      idx_q      <= idx_d;
      run_q      <= run_d;
      display_q  <= display_d;
      pending_q  <= pending_d;
      full_q     <= full_d;
      seg_q      <= seg_d;
      digit_en_q <= digit_en_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.digit_en   = digit_en_q;
  assign bus.digit_idx  = idx_q;
  assign bus.load_ready = ~full_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: directed corner sequences, a vector table
// and a randomized run, all checked every cycle against a frame/slot arithmetic model.
module tb_seg7_scan_driver;
  localparam int N = 4;
  localparam int T = 4;
  localparam int F = N * T;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seg7_scan_if #(.NUM_DIGITS(N)) bus ();

  seg7_scan_driver #(.NUM_DIGITS(N), .TICKS_PER_DIGIT(T)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [6:0] seg_rom [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model state: m_cyc counts edges since the first post-reset edge (-1 = none yet)
  int          m_cyc = -1;
  logic [15:0] m_disp = 16'h0;
  logic [15:0] m_pend = 16'h0;
  bit          m_full = 1'b0;
  bit          m_xfer = 1'b0;
  int          xfer_cyc = 0;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  mask;
    logic [6:0]  exp_seg [4];
  } vec_t;
  vec_t vecs [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_seg(input int cyc, input logic [15:0] disp,
                                           input logic [3:0] mask);
    int slot;
    bit blank;
    int top;
    slot  = (cyc / T) % N;
    blank = mask[slot];
    top   = 0;
    for (int k = 0; k < N; k++) if (disp[k*4 +: 4] != 4'h0) top = k;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (slot > top) blank = 1'b1;
`endif
    return blank ? 7'h7F : seg_rom[disp[slot*4 +: 4]];
  endfunction

  task automatic check_outputs();
    int slot;
    int tick;
    logic [3:0] en_exp;
    slot   = (m_cyc / T) % N;
    tick   = m_cyc % T;
    en_exp = (tick == 0) ? 4'hF : 4'(~(4'b0001 << slot));
    chk("seg", bus.seg, model_seg(m_cyc, m_disp, bus.blank_mask));
    chk("digit_en", bus.digit_en, en_exp);
    chk("digit_idx", bus.digit_idx, slot);
    chk("load_ready", bus.load_ready, !m_full);
  endtask

  task automatic step();
    bit boundary;
    @(posedge clk);
    boundary = (m_cyc >= 0) && (m_cyc % F == F - 1);
    m_xfer   = bus.load_valid && !m_full;
    if (boundary && m_full) begin
      m_disp = m_pend;
      m_full = 1'b0;
    end else if (m_xfer) begin
      m_pend   = bus.value;
      m_full   = 1'b1;
      xfer_cyc = m_cyc;
      $display("xfer value=%h cyc=%0d", bus.value, m_cyc);
    end
    m_cyc++;
    #1 check_outputs();
  endtask

  task automatic rst_chk(input string tag);
    chk({tag, "_seg"}, bus.seg, 7'h7F);
    chk({tag, "_digit_en"}, bus.digit_en, 4'hF);
    chk({tag, "_digit_idx"}, bus.digit_idx, 0);
    chk({tag, "_load_ready"}, bus.load_ready, 1);
  endtask

  task automatic async_reset();
    bus.load_valid = 1'b0;
    rst = 1'b1;
    #1 rst_chk("rst_immediate");
    m_cyc  = -1;
    m_disp = 16'h0;
    m_pend = 16'h0;
    m_full = 1'b0;
    @(posedge clk);
    #1 rst_chk("rst_held");
    @(negedge clk);
    rst = 1'b0;
    #1 rst_chk("rst_released");
  endtask

  task automatic run_to(input int slot, input int tick);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 2 * F; i++) begin
      step();
      if ((m_cyc / T) % N == slot && m_cyc % T == tick) begin
        found = 1'b1;
        break;
      end
    end
    chk("run_to_reached", found, 1);
  endtask

  task automatic load(input logic [15:0] v);
    bit found;
    found = 1'b0;
    bus.value      = v;
    bus.load_valid = 1'b1;
    for (int i = 0; i < 3 * F; i++) begin
      step();
      if (m_xfer) begin
        found = 1'b1;
        break;
      end
    end
    bus.load_valid = 1'b0;
    chk("load_accepted", found, 1);
  endtask

  initial begin
    logic [6:0] ref_seg;
    logic [6:0] lz_seg;
    bit         found;

    vecs[0].value = 16'hFEDC; vecs[0].mask = 4'b0000;
    vecs[0].exp_seg = '{7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[1].value = 16'h9876; vecs[1].mask = 4'b0000;
    vecs[1].exp_seg = '{7'h02, 7'h78, 7'h00, 7'h10};
    vecs[2].value = 16'hB5A0; vecs[2].mask = 4'b0001;
    vecs[2].exp_seg = '{7'h7F, 7'h08, 7'h12, 7'h03};
    vecs[3].value = 16'h3210; vecs[3].mask = 4'b1000;
    vecs[3].exp_seg = '{7'h40, 7'h79, 7'h24, 7'h7F};
    vecs[4].value = 16'hFFFF; vecs[4].mask = 4'b1111;
    vecs[4].exp_seg = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};

    bus.value      = 16'h0;
    bus.load_valid = 1'b0;
    bus.blank_mask = 4'h0;

    #2 async_reset();

    // First edge after release is the guard tick of slot 0
    step();
    chk("first_tick_digit_en", bus.digit_en, 4'hF);
    chk("first_tick_idx", bus.digit_idx, 0);

    // 1234 becomes visible from the frame after the first boundary
    load(16'h1234);
    chk("ready_low_after_load", bus.load_ready, 0);
    run_to(0, 1);
    chk("d1234_slot0_seg", bus.seg, 7'h19);
    chk("d1234_slot0_en_t1", bus.digit_en, 4'b1110);
    step();
    chk("d1234_slot0_en_t2", bus.digit_en, 4'b1110);
    step();
    chk("d1234_slot0_en_t3", bus.digit_en, 4'b1110);
    run_to(3, 1);
    chk("d1234_slot3_seg", bus.seg, 7'h79);
    chk("d1234_slot3_en", bus.digit_en, 4'b0111);

    // AAAA then 5555 held: 5555 taken on the cycle right after the swap boundary
    load(16'hAAAA);
    bus.value      = 16'h5555;
    bus.load_valid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 3 * F; i++) begin
      step();
      if (m_xfer) begin
        found = 1'b1;
        break;
      end
    end
    bus.load_valid = 1'b0;
    chk("held_5555_accepted", found, 1);
    chk("accept_after_boundary", xfer_cyc % F, 0);
    for (int fr = 0; fr < 3; fr++) begin
      run_to(0, 1);
      ref_seg = bus.seg;
      chk("frame_digit_legal", (ref_seg == 7'h08) || (ref_seg == 7'h12), 1);
      for (int s = 1; s < N; s++) begin
        run_to(s, 1);
        chk("frame_no_mix", bus.seg, ref_seg);
      end
    end

    // blank_mask forces only slot 2 dark
    load(16'h8888);
    repeat (2 * F) step();
    bus.blank_mask = 4'b0100;
    for (int s = 0; s < N; s++) begin
      run_to(s, 1);
      chk($sformatf("mask_slot%0d", s), bus.seg, (s == 2) ? 7'h7F : 7'h00);
    end
    bus.blank_mask = 4'b0000;

    // Leading zeros depend on the build option
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    lz_seg = 7'h7F;
`else
    lz_seg = 7'h40;
`endif
    load(16'h0042);
    repeat (2 * F) step();
    run_to(0, 1);
    chk("lz_slot0", bus.seg, 7'h24);
    run_to(1, 1);
    chk("lz_slot1", bus.seg, 7'h19);
    run_to(2, 1);
    chk("lz_slot2", bus.seg, lz_seg);
    run_to(3, 1);
    chk("lz_slot3", bus.seg, lz_seg);

    for (int v = 0; v < 5; v++) begin
      bus.blank_mask = vecs[v].mask;
      load(vecs[v].value);
      repeat (2 * F) step();
      for (int s = 0; s < N; s++) begin
        run_to(s, 2);
        chk($sformatf("vec%0d_slot%0d", v, s), bus.seg, vecs[v].exp_seg[s]);
      end
    end
    bus.blank_mask = 4'b0000;

    // Reset mid-frame with a pending value discards both registers
    run_to(0, 1);
    load(16'h9999);
    run_to(2, 2);
    chk("pending_full_before_rst", bus.load_ready, 0);
    async_reset();
    step();
    chk("post_rst_tick0_en", bus.digit_en, 4'hF);
    chk("post_rst_tick0_idx", bus.digit_idx, 0);
    step();
    chk("post_rst_t1_en", bus.digit_en, 4'b1110);
    chk("post_rst_display_cleared", bus.seg, 7'h40);
    repeat (2 * F) step();

    for (int i = 0; i < 800; i++) begin
      bus.load_valid = ($urandom_range(0, 3) == 0);
      bus.value      = 16'($urandom);
      if ($urandom_range(0, 31) == 0) bus.blank_mask = 4'($urandom);
      step();
    end
    bus.load_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
